// File: rtl/i_fetch_pkg.sv
// i_fetch_pkg: shared defaults for the instruction fetch stage
package i_fetch_pkg;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int RESET_PC_DEF   = 0;
    localparam int PERF_CNT_W     = 32;
endpackage

// File: rtl/fetch_sat_counter.sv
// fetch_sat_counter: saturating event counter used by the fetch perf monitors
module fetch_sat_counter
    import i_fetch_pkg::*;
#(
    parameter int WIDTH = PERF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    // count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
endmodule

// File: rtl/i_fetch.sv
// i_fetch: PC owner feeding a 1-cycle synchronous instruction RAM; I_FETCH_PERF_EN adds perf counters
module i_fetch
    import i_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RESET_PC   = RESET_PC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    output logic                  mem_r_en,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
`ifdef I_FETCH_PERF_EN
    output logic [PERF_CNT_W-1:0] perf_fetch_cnt,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
`endif
    output logic                  instr_valid
);
    localparam logic [ADDR_WIDTH-1:0] PC0 = ADDR_WIDTH'(RESET_PC);
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  valid_q;
    // redirect overrides stall; stall freezes the RAM so dout (and instr) holds
    always_comb begin
        mem_r_en    = !rst && (redirect || !stall);
        mem_r_addr  = redirect ? redirect_addr : pc;
        instr       = mem_dout;
        instr_pc    = pc_q;
        instr_valid = valid_q;
    end
    // advance the PC on every issued read; the issued address becomes the presented pc next cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc      <= PC0;
            pc_q    <= PC0;
            valid_q <= 1'b0;
        end else if (redirect || !stall) begin
            pc      <= mem_r_addr + 1'b1;
            pc_q    <= mem_r_addr;
            valid_q <= 1'b1;
        end
`ifdef I_FETCH_PERF_EN
    fetch_sat_counter #(.WIDTH(PERF_CNT_W)) u_fetch_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (valid_q && !stall),
        .count(perf_fetch_cnt)
    );
    fetch_sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (valid_q && stall),
        .count(perf_stall_cnt)
    );
`endif
endmodule

// File: tb/tb_i_fetch.sv
// tb_i_fetch: fetch stage paired with a read-first sync RAM, checked against a behavioural model
module tb_i_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_addr = '0;
    logic [11:0] mem_r_addr;
    logic        mem_r_en;
    logic [15:0] mem_dout;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
`ifdef I_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    longint      m_fetch;
    longint      m_stall;
`endif
    logic [15:0] mem [4096];
    int          n_chk = 0;
    int          n_fail = 0;
    int          m_next;
    int          m_pc;
    int          m_valid;

    i_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .mem_r_addr   (mem_r_addr),
        .mem_r_en     (mem_r_en),
        .mem_dout     (mem_dout),
        .instr        (instr),
        .instr_pc     (instr_pc),
`ifdef I_FETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .instr_valid  (instr_valid)
    );

    always #5 clk = ~clk;

    initial for (int k = 0; k < 4096; k++) mem[k] = 16'hA000 + 16'(k);

    // instruction RAM: registered, read-first, dout holds while r_en is low
    always @(posedge clk) if (mem_r_en) mem_dout <= mem[mem_r_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: which word address the fetch stage must present, from the port rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_next  <= 0;
            m_pc    <= 0;
            m_valid <= 0;
`ifdef I_FETCH_PERF_EN
            m_fetch <= 0;
            m_stall <= 0;
`endif
        end else begin
`ifdef I_FETCH_PERF_EN
            if (m_valid != 0 && !stall && m_fetch < 64'hFFFF_FFFF) m_fetch <= m_fetch + 1;
            if (m_valid != 0 && stall && m_stall < 64'hFFFF_FFFF) m_stall <= m_stall + 1;
`endif
            if (redirect) begin
                m_pc    <= int'(redirect_addr);
                m_next  <= (int'(redirect_addr) + 1) % 4096;
                m_valid <= 1;
            end else if (!stall) begin
                m_pc    <= m_next;
                m_next  <= (m_next + 1) % 4096;
                m_valid <= 1;
            end
        end
    end

    // compare every cycle, mid-period, away from the active edge
    always @(negedge clk) begin
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr_pc", 32'(instr_pc), 32'(m_pc));
        if (m_valid != 0) chk("instr", 32'(instr), 32'hA000 + 32'(m_pc));
        chk("mem_r_en", 32'(mem_r_en), 32'(!rst && (redirect || !stall)));
        if (!rst && (redirect || !stall))
            chk("mem_r_addr", 32'(mem_r_addr), redirect ? 32'(redirect_addr) : 32'(m_next));
`ifdef I_FETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetch));
        chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_r_en", 32'(mem_r_en), 32'd0);
        rst = 1'b0;
        #1;
        chk("c0_r_addr", 32'(mem_r_addr), 32'd0);
        chk("c0_r_en", 32'(mem_r_en), 32'd1);
        tick();
        chk("c1_instr", 32'(instr), 32'hA000);
        chk("c1_pc", 32'(instr_pc), 32'd0);
        chk("c1_valid", 32'(instr_valid), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_pc", 32'(instr_pc), 32'(i));
        end
        tick();
        tick();
        chk("pre_stall_pc", 32'(instr_pc), 32'd5);
        stall = 1'b1;
        #1;
        chk("stall_r_en", 32'(mem_r_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 32'(instr_pc), 32'd5);
            chk("stall_instr", 32'(instr), 32'hA005);
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("post_stall_pc", 32'(instr_pc), 32'd6);
        tick();
        chk("pre_redir_pc", 32'(instr_pc), 32'd7);
        redirect = 1'b1;
        redirect_addr = 12'h100;
        tick();
        redirect = 1'b0;
        chk("redir_pc", 32'(instr_pc), 32'h100);
        chk("redir_instr", 32'(instr), 32'hA100);
        tick();
        chk("redir_next_pc", 32'(instr_pc), 32'h101);
        redirect = 1'b1;
        stall = 1'b1;
        redirect_addr = 12'h020;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        chk("redir_stall_pc", 32'(instr_pc), 32'h020);
        chk("redir_stall_valid", 32'(instr_valid), 32'd1);
        redirect = 1'b1;
        redirect_addr = 12'hFFF;
        tick();
        redirect = 1'b0;
        chk("wrap_top_pc", 32'(instr_pc), 32'hFFF);
        tick();
        chk("wrap_zero_pc", 32'(instr_pc), 32'h000);
        chk("wrap_zero_valid", 32'(instr_valid), 32'd1);
        chk("wrap_zero_instr", 32'(instr), 32'hA000);
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            redirect_addr = ($urandom_range(0, 3) == 0) ? 12'(12'hFFE + $urandom_range(0, 1)) : 12'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end
        stall = 1'b0;
        redirect = 1'b1;
        redirect_addr = 12'd9;
        tick();
        redirect = 1'b0;
        chk("pre_reset_pc", 32'(instr_pc), 32'd9);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_pc", 32'(instr_pc), 32'd0);
`ifdef I_FETCH_PERF_EN
        chk("async_fetch_cnt", perf_fetch_cnt, 32'd0);
        chk("async_stall_cnt", perf_stall_cnt, 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        chk("refetch_pc", 32'(instr_pc), 32'd0);
        chk("refetch_valid", 32'(instr_valid), 32'd1);
        chk("refetch_instr", 32'(instr), 32'hA000);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
